// File: rtl/mod47_stream_reducer.sv
// mod47_stream_reducer
//   Reduces an arbitrarily long binary operand, streamed as W-bit digits with the
//   most-significant digit first, to its residue mod MODULUS. It also reports the
//   digit count, which saturates at 255.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   in_valid     digit present on in_digit
//   in_ready     block can accept a digit (depends only on state)
//   in_digit     operand digit, any value 0..2^W-1
//   in_last      marks the least-significant (final) digit of the operand
//   out_valid    result present
//   out_ready    sink accepts the result
//   out_residue  operand mod MODULUS
//   out_len      number of digits in the operand, saturating at 255
module mod47_stream_reducer #(
    parameter int unsigned MODULUS = 47,
    parameter int unsigned W       = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_digit,
    input  logic         in_last,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_residue,
    output logic [7:0]   out_len
);

    // Radix constant: 2^W folded into the residue domain.
    localparam int unsigned K  = (1 << W) % MODULUS;
    // K*r + d < (MODULUS-1)*K + 2^W < 2^(2W), so 2W bits always hold the sum.
    localparam int unsigned AW = 2 * W;

    localparam logic StAccum = 1'b0;
    localparam logic StDone  = 1'b1;

    logic         state_q, state_d;
    logic [W-1:0] r_q, r_d;
    logic [7:0]   len_q, len_d;
    logic [W-1:0] res_q, res_d;
    logic [7:0]   olen_q, olen_d;

    logic [AW-1:0] k_ext;
    logic [AW-1:0] acc;
    logic [AW-1:0] acc_mod;
    logic [W-1:0]  r_next;
    logic [7:0]    len_inc;
    logic          accept;
    logic          taken;

    assign k_ext   = AW'(K);
    assign acc     = k_ext * {{W{1'b0}}, r_q} + {{W{1'b0}}, in_digit};
    assign acc_mod = acc % AW'(MODULUS);
    assign r_next  = acc_mod[W-1:0];
    assign len_inc = (len_q == 8'hFF) ? 8'hFF : len_q + 8'd1;

    assign in_ready    = (state_q == StAccum);
    assign out_valid   = (state_q == StDone);
    assign out_residue = res_q;
    assign out_len     = olen_q;

    assign accept = in_valid && in_ready;
    assign taken  = out_valid && out_ready;

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        len_d   = len_q;
        res_d   = res_q;
        olen_d  = olen_q;
        case (state_q)
            StAccum: begin
                if (accept) begin
                    if (in_last) begin
                        res_d   = r_next;
                        olen_d  = len_inc;
                        r_d     = '0;
                        len_d   = '0;
                        state_d = StDone;
                    end else begin
                        r_d   = r_next;
                        len_d = len_inc;
                    end
                end
            end
            StDone: begin
                if (taken) begin
                    state_d = StAccum;
                end
            end
            default: state_d = StAccum;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StAccum;
            r_q     <= '0;
            len_q   <= '0;
            res_q   <= '0;
            olen_q  <= '0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            len_q   <= len_d;
            res_q   <= res_d;
            olen_q  <= olen_d;
        end
    end

endmodule

// File: tb/tb_mod47_stream_reducer.sv
module tb_mod47_stream_reducer;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [5:0] in_digit;
    logic       in_last;
    logic       out_valid;
    logic       out_ready;
    logic [5:0] out_residue;
    logic [7:0] out_len;

    int n_checks;
    int n_fail;

    mod47_stream_reducer #(
        .MODULUS(47),
        .W      (6)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_digit   (in_digit),
        .in_last    (in_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_residue(out_residue),
        .out_len    (out_len)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int              n;
        logic [3:0][5:0] d;    // d[0] is the most-significant digit
        logic [5:0]      res;
        logic [7:0]      len;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Drive one digit; returns at the negedge after the accepting posedge.
    task automatic send_digit(input logic [5:0] d, input logic last);
        int t;
        t = 0;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            check("in_ready_timeout", 0, 1);
        end
        in_valid = 1'b1;
        in_digit = d;
        in_last  = last;
        @(negedge clk);
        in_valid = 1'b0;
        in_digit = 6'($urandom);
        in_last  = 1'($urandom);
    endtask

    // Wait for a result, compare, and take it.
    task automatic get_result(input string name, input int exp_res, input int exp_len);
        int t;
        t = 0;
        while (!out_valid && t < 50) begin
            @(negedge clk);
            t++;
        end
        check({name, "_valid"}, int'(out_valid), 1);
        check({name, "_residue"}, int'(out_residue), exp_res);
        check({name, "_len"}, int'(out_len), exp_len);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({name, "_ready_back"}, int'(in_ready), 1);
    endtask

    vec_t vecs[8];

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_digit  = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;

        vecs[0] = '{1, {6'd0, 6'd0, 6'd0, 6'd63}, 6'd16, 8'd1};
        vecs[1] = '{1, {6'd0, 6'd0, 6'd0, 6'd46}, 6'd46, 8'd1};
        vecs[2] = '{1, {6'd0, 6'd0, 6'd0, 6'd47}, 6'd0, 8'd1};
        vecs[3] = '{2, {6'd0, 6'd0, 6'd0, 6'd1}, 6'd17, 8'd2};
        vecs[4] = '{2, {6'd0, 6'd0, 6'd63, 6'd63}, 6'd6, 8'd2};
        vecs[5] = '{3, {6'd0, 6'd0, 6'd0, 6'd1}, 6'd7, 8'd3};
        vecs[6] = '{3, {6'd0, 6'd5, 6'd0, 6'd0}, 6'd5, 8'd3};
        vecs[7] = '{4, {6'd5, 6'd4, 6'd3, 6'd2}, 6'd3, 8'd4};

        // Reset defaults
        repeat (2) @(negedge clk);
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_residue", int'(out_residue), 0);
        check("rst_len", int'(out_len), 0);
        rst = 1'b0;
        @(negedge clk);

        // Table-driven operands
        foreach (vecs[i]) begin
            for (int j = 0; j < vecs[i].n; j++) begin
                send_digit(vecs[i].d[j], j == vecs[i].n - 1);
            end
            check($sformatf("vec%0d_latency", i), int'(out_valid), 1);
            get_result($sformatf("vec%0d", i), int'(vecs[i].res), int'(vecs[i].len));
        end

        // Backpressure with input gaps; in_valid kept high during DONE must be ignored
        repeat (2) @(negedge clk);
        send_digit(6'd63, 1'b0);
        repeat (3) @(negedge clk);
        send_digit(6'd63, 1'b1);
        in_valid = 1'b1;
        in_digit = 6'd11;
        in_last  = 1'b1;
        for (int c = 0; c < 5; c++) begin
            check("bp_in_ready", int'(in_ready), 0);
            check("bp_out_valid", int'(out_valid), 1);
            check("bp_residue", int'(out_residue), 6);
            check("bp_len", int'(out_len), 2);
            @(negedge clk);
        end
        in_valid = 1'b0;
        get_result("bp", 6, 2);
        send_digit(6'd1, 1'b0);
        send_digit(6'd0, 1'b1);
        get_result("bp_next", 17, 2);

        // Mid-operand reset discards the partial operand
        send_digit(6'd5, 1'b0);
        send_digit(6'd9, 1'b0);
        #2 rst = 1'b1;
        #1;
        check("midrst_in_ready", int'(in_ready), 1);
        check("midrst_out_valid", int'(out_valid), 0);
        @(negedge clk);
        rst = 1'b0;
        send_digit(6'd2, 1'b1);
        get_result("midrst", 2, 1);

        // Asynchronous reset while DONE drops the result immediately
        send_digit(6'd63, 1'b1);
        check("done_before_rst", int'(out_valid), 1);
        #2 rst = 1'b1;
        #1;
        check("donerst_out_valid", int'(out_valid), 0);
        check("donerst_in_ready", int'(in_ready), 1);
        check("donerst_residue", int'(out_residue), 0);
        check("donerst_len", int'(out_len), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("donerst_no_result", int'(out_valid), 0);

        // Random regression against a radix-64 reference
        for (int k = 0; k < 150; k++) begin
            int n;
            int ref_r;
            logic [5:0] d;
            if (k == 0) n = 256;
            else if (k == 1) n = 300;
            else if (k == 2) n = 255;
            else n = $urandom_range(1, 300);
            ref_r = 0;
            for (int j = 0; j < n; j++) begin
                d = 6'($urandom);
                ref_r = (ref_r * 64 + int'(d)) % 47;
                if ($urandom_range(0, 7) == 0) @(negedge clk);
                send_digit(d, j == n - 1);
            end
            get_result($sformatf("rand%0d", k), ref_r, (n > 255) ? 255 : n);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
